reg_file_wb: RTL
================

Name: reg_file_wb

Overview:
- General-purpose register file for the multicycle datapath: source of the operand words captured by the A/B operand registers, and sink of the write-back path.
- Provides two asynchronous read ports, one synchronous write port with write-to-read bypass, and a pending-write scoreboard.
- Control uses the scoreboard to stall operand capture while a destination register still awaits write-back.

Parameters:
- DATA_W, 32, register word width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- rs_data  output  DATA_W  read port A data, to operand register A
- rt_data  output  DATA_W  read port B data, to operand register B
- wr_en  input  1  write-back strobe
- wr_addr  input  ADDR_W  write-back destination
- wr_data  input  DATA_W  write-back data
- resv_en  input  1  reserve destination (instruction issued, result pending)
- resv_addr  input  ADDR_W  destination to reserve
- rs_busy  output  1  rs_addr has a pending write
- rt_busy  output  1  rt_addr has a pending write
- pending_cnt  output  ADDR_W+1  number of reserved registers
- resv_err  output  1  one-cycle pulse: reserved an already-pending register

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, asserted asynchronously:
  - All registers become 0.
  - All pending bits are cleared.
  - pending_cnt = 0; resv_err = 0.
  - The read ports then return 0 for every address.
- Reset mid-operation discards any in-flight reservation or write in that cycle. Deassertion is synchronised externally.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Reservations of it are ignored: no pending bit, no count change, no resv_err.
- Reads:
  - Combinational and zero latency.
  - rs_data = regs[rs_addr], with the following exception.
  - If BYPASS=1, wr_en=1, wr_addr=rs_addr and wr_addr!=0, then rs_data = wr_data in the same cycle.
  - rt_data follows the same rule.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data. The value is visible from the next cycle regardless of BYPASS.
- Scoreboard: one pending bit per register.
  - Set: rising edge with resv_en=1 and resv_addr!=0.
  - Clear: rising edge with wr_en=1 and wr_addr!=0.
  - Simultaneous set and clear on the same address: the bit ends set (the new reservation wins). The data write still occurs.
  - Writing a register that is not pending is legal: data is written and the bit stays clear.
  - Reserving a register that is already pending (and not being written that cycle): the bit stays set, pending_cnt is unchanged, and resv_err pulses high for one cycle (registered, asserted the cycle after the edge).
- Busy outputs:
  - rs_busy = pending[rs_addr] & ~(wr_en & wr_addr==rs_addr); rt_busy likewise. A write-back arriving this cycle releases the stall immediately.
  - Busy is 0 for address 0.
- pending_cnt:
  - Registered, and equals the popcount of the pending bits after each edge.
  - Updated incrementally: +1 on a valid new set, −1 on a clear of a set bit, net 0 on a same-address set+clear, ±0 when a different-address set and clear coincide.
  - Range 0..2**ADDR_W−1; overflow is impossible because r0 is excluded.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults
  - REG_ZERO = 0
  - NUM_REGS = 2**ADDR_W
- One natural sub-module: reg_scoreboard, containing the pending bits, pending_cnt, resv_err and busy logic.
- The storage array and the read/bypass muxes stay in reg_file_wb.

Test Plan:
- Reset, then read all 32 addresses on both ports → every rs_data/rt_data = 0, pending_cnt=0, busy=0.
- Write r5=0xDEADBEEF with rs_addr=5 in the same cycle → rs_data=0xDEADBEEF immediately (BYPASS=1); with BYPASS=0 → 0 that cycle, 0xDEADBEEF next cycle.
- Write r0=0xFFFFFFFF, then reserve r0 → reads of r0 stay 0, pending_cnt stays 0, rs_busy=0, no resv_err.
- Reserve r7, then r9 → pending_cnt=2 and rt_busy=1 for rt_addr=7. Write r7=0x12 → rt_busy=0 in the write cycle, pending_cnt=1 after the edge.
- Reserve r3 while r3 is already pending → resv_err high exactly one cycle, pending_cnt unchanged. Then, in the same cycle, write r3 and reserve r3 → r3 updated, bit still set, count unchanged.
- Reserve r4 and r6, assert rst_n=0 between edges → all outputs 0 immediately, no clk edge required.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared sizing constants for the write-back register file and its scoreboard.
package reg_file_wb_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;
   localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, a running pending count,
// a reserve-collision pulse and the operand stall (busy) outputs.
module reg_scoreboard
   import reg_file_wb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              resv_en,
   input  logic [ADDR_W-1:0] resv_addr,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic [ADDR_W:0]   pending_cnt,
   output logic              resv_err
);
   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DEPTH-1:0] pending_q, pending_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             set_v, clr_v, same_v, inc, dec;

   assign set_v  = resv_en && (resv_addr != ADDR_W'(REG_ZERO));
   assign clr_v  = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
   assign same_v = set_v && clr_v && (resv_addr == wr_addr);

   // A new reservation on the address being written wins: the bit stays set
   // and the count is left alone, keeping cnt equal to the popcount.
   assign inc = set_v && !pending_q[resv_addr];
   assign dec = clr_v && pending_q[wr_addr] && !same_v;

   always_comb begin
      pending_d = pending_q;
      cnt_d     = cnt_q;
      err_d     = set_v && pending_q[resv_addr] && !same_v;
      if (clr_v) pending_d[wr_addr] = 1'b0;
      if (set_v) pending_d[resv_addr] = 1'b1;
      case ({inc, dec})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   // pending_q[0] can never be set, so address 0 is never busy.
   assign rs_busy     = pending_q[rs_addr] & ~(wr_en & (wr_addr == rs_addr));
   assign rt_busy     = pending_q[rt_addr] & ~(wr_en & (wr_addr == rt_addr));
   assign pending_cnt = cnt_q;
   assign resv_err    = err_q;
endmodule

// File: rtl/reg_file_wb.sv
// Register file with two combinational read ports, one write-back port with
// optional same-cycle forwarding, and a pending-write scoreboard.
module reg_file_wb
   import reg_file_wb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              resv_en,
   input  logic [ADDR_W-1:0] resv_addr,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic [ADDR_W:0]   pending_cnt,
   output logic              resv_err
);
   localparam int   DEPTH  = 2 ** ADDR_W;
   localparam logic BYP_ON = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              wr_v;

   assign wr_v = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (wr_v) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rs_data = '0;
      if (BYP_ON && wr_v && (wr_addr == rs_addr)) rs_data = wr_data;
      else if (rs_addr != ADDR_W'(REG_ZERO))      rs_data = regs_q[rs_addr];
   end

   always_comb begin
      rt_data = '0;
      if (BYP_ON && wr_v && (wr_addr == rt_addr)) rt_data = wr_data;
      else if (rt_addr != ADDR_W'(REG_ZERO))      rt_data = regs_q[rt_addr];
   end

   reg_scoreboard #(
      .ADDR_W(ADDR_W)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .resv_en    (resv_en),
      .resv_addr  (resv_addr),
      .rs_busy    (rs_busy),
      .rt_busy    (rt_busy),
      .pending_cnt(pending_cnt),
      .resv_err   (resv_err)
   );
endmodule
